// File: rtl/vx_cache_core_req_sched_pkg.sv
// Shared cache configuration for the core request scheduler.
// Holds the scheduler state encoding and the bank-select field geometry.
package vx_cache_core_req_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } sched_state_e;

    // Index width for n items; a single item still gets a 1-bit index.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bank_sel_lo(input int lsb);
        return lsb;
    endfunction

    function automatic int bank_sel_hi(input int lsb, input int num_banks);
        return lsb + sel_width(num_banks) - 1;
    endfunction

endpackage

// File: rtl/vx_cache_core_req_sched_bank_rr_pick.sv
// Round-robin lane picker for one bank.
// Returns a one-hot grant for the first requesting lane at or after rr, with wrap-around.
module vx_cache_bank_rr_pick
    import vx_cache_core_req_sched_pkg::*;
#(
    parameter int NUM_REQUESTS = 4,
    localparam int LANE_W = sel_width(NUM_REQUESTS)
) (
    input  logic [NUM_REQUESTS-1:0] req,
    input  logic [LANE_W-1:0]       rr,
    output logic [NUM_REQUESTS-1:0] grant
);

    logic              found_s;
    logic [LANE_W-1:0] idx_s;

    // Search upward from the pointer and take the first requesting lane
    always_comb begin
        grant   = {NUM_REQUESTS{1'b0}};
        found_s = 1'b0;
        idx_s   = {LANE_W{1'b0}};
        for (int k = 0; k < NUM_REQUESTS; k++) begin
            idx_s = LANE_W'((int'(rr) + k) % NUM_REQUESTS);
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/vx_cache_core_req_sched.sv
// Core request scheduler: accepts a batch of lane requests, then drains it
// by issuing at most one lane per bank per cycle with per-bank round-robin.
module vx_cache_core_req_sched
    import vx_cache_core_req_sched_pkg::*;
#(
    parameter int NUM_BANKS       = 4,
    parameter int NUM_REQUESTS    = 4,
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int BANK_SEL_LSB    = 0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_REQUESTS-1:0]                       core_req_valid,
    input  logic [NUM_REQUESTS-1:0][WORD_ADDR_WIDTH-1:0]  core_req_addr,
    output logic                                          core_req_ready,
    output logic [NUM_BANKS-1:0][NUM_REQUESTS-1:0]        per_bank_valid,
    input  logic [NUM_BANKS-1:0]                          per_bank_ready,
    output logic                                          busy,
    output logic [31:0]                                   conflict_cnt
);

    localparam int BANK_W  = sel_width(NUM_BANKS);
    localparam int LANE_W  = sel_width(NUM_REQUESTS);
    localparam int BSEL_LO = bank_sel_lo(BANK_SEL_LSB);
    localparam int BSEL_HI = bank_sel_hi(BANK_SEL_LSB, NUM_BANKS);

    sched_state_e                            state_r;
    logic [NUM_REQUESTS-1:0]                 pending_r;
    logic [NUM_REQUESTS-1:0][BANK_W-1:0]     bank_r;
    logic [NUM_BANKS-1:0][LANE_W-1:0]        rr_r;
    logic [31:0]                             conflict_cnt_r;
    logic                                    core_req_ready_r;
    logic                                    busy_r;

    logic [NUM_REQUESTS-1:0][BANK_W-1:0]     bank_idx_s;
    logic [NUM_REQUESTS-1:0]                 mask_s  [NUM_BANKS];
    logic [NUM_REQUESTS-1:0]                 grant_s [NUM_BANKS];
    logic [NUM_REQUESTS-1:0]                 granted_s;
    logic [NUM_REQUESTS-1:0]                 fire_mask_s;
    logic [NUM_REQUESTS-1:0]                 pending_next_s;
    logic [NUM_BANKS-1:0][LANE_W-1:0]        rr_next_s;
    logic                                    stall_s;

    // Bank index of each incoming lane; a single bank always maps to 0
    always_comb begin
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            if (NUM_BANKS > 1) begin
                bank_idx_s[i] = core_req_addr[i][BSEL_HI:BSEL_LO];
            end else begin
                bank_idx_s[i] = {BANK_W{1'b0}};
            end
        end
    end

    // Per-bank view of the pending lanes captured with the batch
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_REQUESTS; i++) begin
                mask_s[b][i] = pending_r[i] && (bank_r[i] == BANK_W'(b));
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        vx_cache_bank_rr_pick #(
            .NUM_REQUESTS (NUM_REQUESTS)
        ) u_pick (
            .req   (mask_s[gb]),
            .rr    (rr_r[gb]),
            .grant (grant_s[gb])
        );
    end

    // Consumed lanes, pointer advance and stall detection for this drain cycle
    always_comb begin
        granted_s   = {NUM_REQUESTS{1'b0}};
        fire_mask_s = {NUM_REQUESTS{1'b0}};
        rr_next_s   = rr_r;
        for (int b = 0; b < NUM_BANKS; b++) begin
            granted_s = granted_s | grant_s[b];
            if (per_bank_ready[b] && (|grant_s[b])) begin
                fire_mask_s = fire_mask_s | grant_s[b];
                for (int i = 0; i < NUM_REQUESTS; i++) begin
                    rr_next_s[b] = grant_s[b][i] ? LANE_W'((i + 1) % NUM_REQUESTS) : rr_next_s[b];
                end
            end else begin
                rr_next_s[b] = rr_r[b];
            end
        end
        pending_next_s = pending_r & ~fire_mask_s;
        stall_s        = |(pending_r & ~granted_s);
    end

    // Grants are visible only while draining
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (busy_r) begin
                per_bank_valid[b] = grant_s[b];
            end else begin
                per_bank_valid[b] = {NUM_REQUESTS{1'b0}};
            end
        end
    end

    // Scheduler FSM with registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= ST_IDLE;
            pending_r        <= {NUM_REQUESTS{1'b0}};
            bank_r           <= '0;
            rr_r             <= '0;
            conflict_cnt_r   <= 32'd0;
            core_req_ready_r <= 1'b1;
            busy_r           <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|core_req_valid) begin
                        pending_r        <= core_req_valid;
                        bank_r           <= bank_idx_s;
                        state_r          <= ST_DRAIN;
                        core_req_ready_r <= 1'b0;
                        busy_r           <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    pending_r <= pending_next_s;
                    rr_r      <= rr_next_s;
                    if (stall_s) begin
                        conflict_cnt_r <= conflict_cnt_r + 32'd1;
                    end
                    if (pending_next_s == {NUM_REQUESTS{1'b0}}) begin
                        state_r          <= ST_IDLE;
                        core_req_ready_r <= 1'b1;
                        busy_r           <= 1'b0;
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    pending_r        <= {NUM_REQUESTS{1'b0}};
                    core_req_ready_r <= 1'b1;
                    busy_r           <= 1'b0;
                end
            endcase
        end
    end

    assign core_req_ready = core_req_ready_r;
    assign busy           = busy_r;
    assign conflict_cnt   = conflict_cnt_r;

endmodule

// File: tb/tb_vx_cache_core_req_sched.sv
// Directed bench for the core request scheduler with hand-computed grant sequences.
module tb_vx_cache_core_req_sched;

    localparam int NB = 4;
    localparam int NR = 4;
    localparam int AW = 30;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NR-1:0]            core_req_valid;
    logic [NR-1:0][AW-1:0]    core_req_addr;
    logic                     core_req_ready;
    logic [NB-1:0][NR-1:0]    per_bank_valid;
    logic [NB-1:0]            per_bank_ready;
    logic                     busy;
    logic [31:0]              conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vx_cache_core_req_sched #(
        .NUM_BANKS       (NB),
        .NUM_REQUESTS    (NR),
        .WORD_ADDR_WIDTH (AW),
        .BANK_SEL_LSB    (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .core_req_valid (core_req_valid),
        .core_req_addr  (core_req_addr),
        .core_req_ready (core_req_ready),
        .per_bank_valid (per_bank_valid),
        .per_bank_ready (per_bank_ready),
        .busy           (busy),
        .conflict_cnt   (conflict_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic rdy, input logic bsy,
                             input logic [15:0] pbv, input int cnt);
        check_val({tag, ".ready"}, 64'(core_req_ready), 64'(rdy));
        check_val({tag, ".busy"},  64'(busy),           64'(bsy));
        check_val({tag, ".pbv"},   64'(per_bank_valid), 64'(pbv));
        check_val({tag, ".cnt"},   64'(conflict_cnt),   64'(cnt));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_addr(input int a0, input int a1, input int a2, input int a3);
        core_req_addr[0] = AW'(a0);
        core_req_addr[1] = AW'(a1);
        core_req_addr[2] = AW'(a2);
        core_req_addr[3] = AW'(a3);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        core_req_valid = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        core_req_valid = 4'b1111;
        core_req_addr  = '0;
        per_bank_ready = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk_state("reset", 1'b1, 1'b0, 16'h0000, 0);
        core_req_valid = 4'b0000;
        reset = 1'b1;
        step();
        chk_state("idle_novalid", 1'b1, 1'b0, 16'h0000, 0);

        // conflict-free batch: one lane per bank
        core_req_valid = 4'b1111;
        set_addr(0, 1, 2, 3);
        step();
        core_req_valid = 4'b0000;
        chk_state("cf_d1", 1'b0, 1'b1, 16'h8421, 0);
        step();
        chk_state("cf_done", 1'b1, 1'b0, 16'h0000, 0);

        // full conflict on bank 0
        do_reset();
        core_req_valid = 4'b1111;
        set_addr(0, 4, 8, 12);
        step();
        core_req_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            chk_state($sformatf("fc_d%0d", k + 1), 1'b0, 1'b1, 16'(16'h0001 << k), k);
            step();
        end
        chk_state("fc_done", 1'b1, 1'b0, 16'h0000, 3);

        // backpressure on bank 1 for three cycles
        core_req_valid = 4'b0011;
        set_addr(0, 1, 0, 0);
        per_bank_ready = 4'b1101;
        step();
        core_req_valid = 4'b0000;
        chk_state("bp_d1", 1'b0, 1'b1, 16'h0021, 3);
        step();
        chk_state("bp_d2", 1'b0, 1'b1, 16'h0020, 3);
        step();
        chk_state("bp_d3", 1'b0, 1'b1, 16'h0020, 3);
        step();
        chk_state("bp_d4", 1'b0, 1'b1, 16'h0020, 3);
        per_bank_ready = 4'b1111;
        step();
        chk_state("bp_done", 1'b1, 1'b0, 16'h0000, 3);

        // round-robin fairness across two batches on bank 0
        do_reset();
        core_req_valid = 4'b0101;
        set_addr(0, 0, 4, 0);
        step();
        core_req_valid = 4'b0000;
        chk_state("rr1_d1", 1'b0, 1'b1, 16'h0001, 0);
        step();
        chk_state("rr1_d2", 1'b0, 1'b1, 16'h0004, 1);
        step();
        chk_state("rr1_done", 1'b1, 1'b0, 16'h0000, 1);
        core_req_valid = 4'b1001;
        set_addr(8, 0, 0, 12);
        step();
        core_req_valid = 4'b1111;
        set_addr(1, 2, 3, 5);
        chk_state("rr2_d1", 1'b0, 1'b1, 16'h0008, 1);
        step();
        chk_state("rr2_d2", 1'b0, 1'b1, 16'h0001, 2);
        core_req_valid = 4'b0000;
        step();
        chk_state("rr2_done", 1'b1, 1'b0, 16'h0000, 2);

        // reset asserted in the second drain cycle of a full conflict
        do_reset();
        core_req_valid = 4'b1111;
        set_addr(0, 4, 8, 12);
        step();
        core_req_valid = 4'b0000;
        chk_state("md_d1", 1'b0, 1'b1, 16'h0001, 0);
        step();
        chk_state("md_d2", 1'b0, 1'b1, 16'h0002, 1);
        reset = 1'b0;
        #1;
        chk_state("md_rst", 1'b1, 1'b0, 16'h0000, 0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_state($sformatf("md_after%0d", k), 1'b1, 1'b0, 16'h0000, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
